// File: rtl/imem_loader.sv
// Instruction-memory loader: unpacks a length-prefixed byte stream into big-endian
// 32-bit words and writes them to the CPU instruction store while holding the CPU.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_ld
);

  localparam int               DEPTH   = 2 ** ADDR_W;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       pack_q, pack_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              xfer;
  logic [LEN_W-1:0]  new_len;

  assign in_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign xfer      = in_valid && in_ready;
  assign cpu_hold  = in_ready || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = ptr_q;
  assign mem_wdata = pack_q;
  assign words_ld  = words_q;
  // Length bytes arrive MSB first, so each one shifts in from the bottom.
  assign new_len   = {len_q[LEN_W-9:0], in_data};

  // NOTE: every next-state signal takes its current value first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pack_d     = pack_q;
    byte_cnt_d = byte_cnt_q;
    ptr_d      = ptr_q;
    words_d    = words_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          len_d      = '0;
          pack_d     = '0;
          byte_cnt_d = '0;
          ptr_d      = '0;
          words_d    = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = new_len;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = new_len;
          state_d = ((new_len == '0) || (new_len > DEPTH_L)) ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          pack_d     = {pack_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ptr_d   = ptr_q + 1'b1;
        words_d = words_q + 1'b1;
        state_d = (LEN_W'(words_d) == len_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      pack_q     <= '0;
      byte_cnt_q <= '0;
      ptr_q      <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pack_q     <= pack_d;
      byte_cnt_q <= byte_cnt_d;
      ptr_q      <= ptr_d;
      words_q    <= words_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte-count session model checked every cycle,
// plus directed sessions with literal expectations on the resulting memory image.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 1024;

  logic              clock = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, mem_we, cpu_hold, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   words_ld;

  imem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_ld(words_ld)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction store the loader writes into.
  logic [31:0] mem_img [DEPTH];
  int          wr_count = 0;
  always @(posedge clock) begin
    if (mem_we) begin
      mem_img[mem_addr] <= mem_wdata;
      wr_count = wr_count + 1;
    end
  end

  // Session model: counts accepted bytes; every 4th data byte owes exactly one write
  // in the following cycle, and the session ends when N writes have been issued.
  bit         m_active = 0, m_done = 0, m_err = 0, m_pend = 0;
  int         m_acc = 0, m_n = 0, m_words = 0;
  logic [7:0] m_b [0:2+4*DEPTH-1];

  always @(negedge clock) begin
    bit          exp_ready, xfer, was_active;
    int          idx;
    logic [31:0] exp_w;
    if (reset) begin
      m_active = 0; m_done = 0; m_err = 0; m_pend = 0;
      m_acc = 0; m_n = 0; m_words = 0;
    end
    exp_ready = m_active && !m_pend;
    check("in_ready", in_ready, exp_ready);
    check("mem_we", mem_we, m_pend);
    check("cpu_hold", cpu_hold, m_active);
    check("done", done, m_done);
    check("error", error, m_err);
    check("words_ld", words_ld, m_words);
    if (m_pend) begin
      idx   = 2 + 4 * m_words;
      exp_w = {m_b[idx], m_b[idx+1], m_b[idx+2], m_b[idx+3]};
      check("mem_addr", mem_addr, m_words);
      check("mem_wdata", mem_wdata, exp_w);
    end
    if (reset) begin
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
    end else begin
      was_active = m_active;
      xfer       = in_valid && exp_ready;
      if (m_pend) begin
        m_pend = 0;
        m_words++;
        if (m_words == m_n) begin m_active = 0; m_done = 1; end
      end else if (xfer) begin
        m_b[m_acc] = in_data;
        m_acc++;
        if (m_acc == 2) begin
          m_n = {m_b[0], m_b[1]};
          if (m_n == 0 || m_n > DEPTH) begin m_active = 0; m_err = 1; end
        end else if (m_acc > 2 && (m_acc - 2) % 4 == 0) begin
          m_pend = 1;
        end
      end
      if (start && !was_active) begin
        m_active = 1; m_done = 0; m_err = 0; m_acc = 0; m_words = 0;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      k++;
      if (k > 50) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(done || error)) begin
      @(negedge clock);
      k++;
      if (k > 50) begin
        check("end_timeout", 0, 1);
        break;
      end
    end
  endtask

  int wr_base;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_words_ld", words_ld, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // 1: two-word program
    wr_base = wr_count;
    pulse_start();
    check("t1_hold_after_start", cpu_hold, 1);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h20, 0); send_byte(8'h09, 0); send_byte(8'h00, 0); send_byte(8'h0f, 0);
    send_byte(8'h20, 0); send_byte(8'h0a, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
    wait_end();
    check("t1_done", done, 1);
    check("t1_hold_low", cpu_hold, 0);
    check("t1_words_ld", words_ld, 2);
    check("t1_word0", mem_img[0], 32'h2009000f);
    check("t1_word1", mem_img[1], 32'h200a0007);
    check("t1_writes", wr_count - wr_base, 2);

    // 2: illegal lengths 0 and 1025
    wr_base = wr_count;
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_end();
    check("t2_err_zero", error, 1);
    check("t2_done_zero", done, 0);
    pulse_start();
    send_byte(8'h04, 0); send_byte(8'h01, 0);
    wait_end();
    check("t2_err_big", error, 1);
    check("t2_hold", cpu_hold, 0);
    check("t2_writes", wr_count - wr_base, 0);

    // 3: single word with a gappy source
    wr_base = wr_count;
    pulse_start();
    send_byte(8'h00, $urandom_range(0, 3)); send_byte(8'h01, $urandom_range(0, 3));
    send_byte(8'h01, $urandom_range(0, 3)); send_byte(8'h2a, $urandom_range(0, 3));
    send_byte(8'h58, $urandom_range(0, 3)); send_byte(8'h24, $urandom_range(0, 3));
    check("t3_we_next_cycle", mem_we, 1);
    @(posedge clock); #1;
    check("t3_we_one_cycle", mem_we, 0);
    wait_end();
    check("t3_word0", mem_img[0], 32'h012a5824);
    check("t3_writes", wr_count - wr_base, 1);
    check("t3_words_ld", words_ld, 1);

    // 4: full 1024-word load, word k = k
    pulse_start();
    send_byte(8'h04, 0); send_byte(8'h00, 0);
    for (int k = 0; k < DEPTH; k++) begin
      logic [15:0] kv;
      kv = 16'(k);
      send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(kv[15:8], 0); send_byte(kv[7:0], 0);
    end
    wait_end();
    check("t4_done", done, 1);
    check("t4_words_ld", words_ld, 1024);
    check("t4_last", mem_img[1023], 32'h000003ff);
    check("t4_mid", mem_img[512], 32'h00000200);

    // 5: reset after 6 data bytes of a 3-word session
    wr_base = wr_count;
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    reset = 1'b1;
    #1;
    check("t5_in_ready", in_ready, 0);
    check("t5_mem_we", mem_we, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_mem_wdata", mem_wdata, 0);
    check("t5_cpu_hold", cpu_hold, 0);
    check("t5_done", done, 0);
    check("t5_error", error, 0);
    check("t5_words_ld", words_ld, 0);
    check("t5_writes", wr_count - wr_base, 1);
    check("t5_word0", mem_img[0], 32'h11223344);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'ha1, 0); send_byte(8'hb2, 0); send_byte(8'hc3, 0); send_byte(8'hd4, 0);
    wait_end();
    check("t5_reload", mem_img[0], 32'ha1b2c3d4);
    check("t5_reload_done", done, 1);

    // 6: start during DATA is ignored; stray bytes after DONE are refused
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'hde, 0); send_byte(8'had, 0); send_byte(8'hbe, 0); send_byte(8'hef, 0);
    send_byte(8'hca, 0); send_byte(8'hfe, 0);
    pulse_start();
    check("t6_hold_mid", cpu_hold, 1);
    send_byte(8'hba, 0); send_byte(8'hbe, 0);
    wait_end();
    check("t6_words_ld", words_ld, 2);
    check("t6_word0", mem_img[0], 32'hdeadbeef);
    check("t6_word1", mem_img[1], 32'hcafebabe);
    wr_base  = wr_count;
    in_valid = 1'b1;
    in_data  = 8'hff;
    repeat (5) begin
      @(negedge clock);
      check("t6_stray_ready", in_ready, 0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("t6_stray_writes", wr_count - wr_base, 0);
    check("t6_still_done", done, 1);

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
